nested_int_ctrl: RTL and testbench
==================================

Name: nested_int_ctrl

Overview:
- Nested-interrupt controller for the multi-cycle/pipelined MIPS CPU; produces the push/pop command stream that drives the EPC stack.
- Latches edge-triggered interrupt requests and arbitrates them by priority.
- Decides when an interrupt may pre-empt the current context.
- Issues EPC push on entry and EPC pop on ERET.
- Maintains a matching priority-level stack so nesting depth and current level always mirror the EPC stack contents.

Parameters:
- NUM_IRQ, 3, number of interrupt sources; index NUM_IRQ-1 = highest priority.
- DEPTH, 4, maximum nesting depth; equals EPC stack capacity.
- VEC_BASE, 32'h0000_1000, handler address of irq 0.
- VEC_STRIDE_LOG2, 8, handler spacing; vector = VEC_BASE + (idx << VEC_STRIDE_LOG2).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- irq_req  in  NUM_IRQ  raw request lines; a rising edge raises a request.
- int_en  in  1  global interrupt enable from the status register.
- ready  in  1  pipeline can accept a redirect this cycle (not stalled).
- eret  in  1  single-cycle pulse when ERET commits.
- pc_cur  in  32  resume PC, i.e. the address to return to.
- epc_en  out  1  EPC stack enable.
- epc_sel  out  1  EPC stack op; 0 = push, 1 = pop.
- epc_data  out  32  value to push.
- int_take  out  1  one-cycle flush/redirect pulse.
- int_vector  out  32  handler address; valid while int_take = 1.
- eret_done  out  1  one-cycle pulse; tells the fetch unit to use the EPC stack top as next PC.
- cur_level  out  2..  current priority level; width clog2(NUM_IRQ+1); 0 = base program, k = irq k-1.
- depth  out  clog2(DEPTH+1)  current nesting depth.
- pending  out  NUM_IRQ  latched pending requests.

Behaviour:

Reset (rst = 0 at posedge):
- State -> RUN.
- pending, edge-detect history, level stack, depth, cur_level all 0.
- All outputs 0.
- Reset mid-ENTER/RETURN aborts the operation; no epc_en is issued in the following cycle.

Edge detect and pending:
- prev <= irq_req each cycle.
- pending[i] is set when irq_req[i] & ~prev[i].
- pending[i] is cleared in the ENTER cycle that services i.
- A set and a clear of the same bit in one cycle: set wins.
- Repeated edges on an already-pending bit merge into one request.

Arbitration (combinational in RUN):
- win = highest index with pending set; wlev = win + 1.
- A request is eligible when int_en & ready & (pending != 0) & (wlev > cur_level) & (depth < DEPTH).

FSM states: RUN, ENTER, RETURN.

RUN:
- If eret and depth > 0 -> RETURN. ERET has priority over a new entry; the request stays pending.
- Else if eligible: capture pc_cur into epc_data_r, record win, -> ENTER.
- eret while depth = 0 is ignored; no output pulses.

ENTER (exactly 1 cycle; outputs are registered, so they appear in this cycle):
- epc_en = 1, epc_sel = 0, epc_data = captured PC.
- int_take = 1, int_vector = VEC_BASE + (win << VEC_STRIDE_LOG2).
- Push cur_level onto the level stack; cur_level <= win + 1; depth <= depth + 1; clear pending[win].
- -> RUN.

RETURN (exactly 1 cycle):
- epc_en = 1, epc_sel = 1, eret_done = 1.
- Pop the level stack into cur_level; depth <= depth - 1.
- -> RUN.

Latency and back-to-back:
- Request edge at cycle n -> pending at n+1 -> decision at n+1 -> int_take and push at n+2.
- Minimum spacing between two entries is 2 cycles; entries are never back-to-back.
- Equal or lower priority than cur_level waits until RETURN lowers the level.
- At depth = DEPTH, no entry occurs; requests stay pending with no overflow push.
- epc_en is never asserted with epc_sel = 1 when depth = 0, so the EPC stack never underflows.
- epc_data holds its last captured value outside ENTER.

Test Plan:
1. Reset, int_en = 1, ready = 1, pc_cur = 32'h40; pulse irq_req[0] -> two cycles later: int_take = 1, int_vector = 32'h1000, epc_en = 1, epc_sel = 0, epc_data = 32'h40; cur_level = 1, depth = 1, pending = 0.
2. While in level 1, raise irq_req[2] with pc_cur = 32'h1010 -> push 32'h1010, int_vector = 32'h1200, cur_level = 3, depth = 2. Then raise irq_req[1] -> stays pending, no take. eret -> epc_sel = 1 pop, eret_done, cur_level = 1. Next, irq 1 is taken: int_vector = 32'h1100, cur_level = 2.
3. eret and a new higher-priority edge pending in the same RUN cycle -> RETURN first (pop, depth--), then ENTER on the following decision.
4. Saturate to depth = 4 using NUM_IRQ = 5 or by forcing levels -> a further higher-priority edge gives no epc_en and no int_take; pending bit stays 1 until a RETURN.
5. eret pulse at depth = 0 -> no epc_en, no eret_done, state unchanged. Same test with int_en = 0 or ready = 0 while pending: no take until both are 1, then take the next cycle.
6. Assert rst = 0 during the ENTER cycle -> next cycle all outputs 0, depth = 0, pending = 0, and no pop/push is emitted afterwards.

Source files
------------

// File: rtl/nested_int_ctrl.sv
// nested_int_ctrl
// Nested-interrupt controller for a multi-cycle/pipelined MIPS CPU. It latches
// edge-triggered requests, arbitrates them by priority, decides when an
// interrupt may pre-empt the running context, and emits the push/pop command
// stream for the EPC stack. A private stack of priority levels shadows the EPC
// stack, so depth and cur_level always agree with the EPC stack contents.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   rst        synchronous reset, active-low
//   irq_req    raw request lines, rising edge raises a request
//   int_en     global interrupt enable
//   ready      pipeline can accept a redirect this cycle
//   eret       one-cycle pulse when ERET commits
//   pc_cur     resume PC to save on entry
//   epc_en     EPC stack enable
//   epc_sel    EPC stack op (0 = push, 1 = pop)
//   epc_data   value to push (holds last captured PC)
//   int_take   one-cycle flush/redirect pulse
//   int_vector handler address, valid while int_take = 1 (0 otherwise)
//   eret_done  one-cycle pulse: fetch uses EPC stack top as next PC
//   cur_level  current priority level (0 = base program, k = irq k-1)
//   depth      current nesting depth
//   pending    latched pending requests
//   state_dbg  FSM state (0 = RUN, 1 = ENTER, 2 = RETURN)
//
// Handshake: the controller only offers a redirect when ready = 1 in the
// decision cycle; int_take then fires unconditionally in the next cycle, and
// the pipeline must accept it (ready is a permission, not a per-cycle stall
// of an already issued redirect).
module nested_int_ctrl #(
  parameter int          NUM_IRQ         = 3,
  parameter int          DEPTH           = 4,
  parameter logic [31:0] VEC_BASE        = 32'h0000_1000,
  parameter int          VEC_STRIDE_LOG2 = 8,
  localparam int         LW              = $clog2(NUM_IRQ + 1),
  localparam int         DW              = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               int_en,
  input  logic               ready,
  input  logic               eret,
  input  logic [31:0]        pc_cur,
  output logic               epc_en,
  output logic               epc_sel,
  output logic [31:0]        epc_data,
  output logic               int_take,
  output logic [31:0]        int_vector,
  output logic               eret_done,
  output logic [LW-1:0]      cur_level,
  output logic [DW-1:0]      depth,
  output logic [NUM_IRQ-1:0] pending,
  output logic [1:0]         state_dbg
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ENTER  = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  state_t             state_r, state_nxt;
  logic [NUM_IRQ-1:0] prev_r;
  logic [NUM_IRQ-1:0] pending_r, pending_nxt, clr_mask;
  logic [LW-1:0]      cur_level_r;
  logic [DW-1:0]      depth_r, depth_m1;
  logic [LW-1:0]      lvl_stack [DEPTH];
  logic [31:0]        epc_data_r;
  logic [IW-1:0]      win, win_r;
  logic [LW-1:0]      wlev, wlev_r;
  logic               eligible;
  logic               capture;
  logic [AW-1:0]      push_idx, pop_idx;

  // Priority arbitration: the highest set index wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending_r[i]) win = IW'(i);
    end
  end

  assign wlev   = LW'(win) + LW'(1);
  assign wlev_r = LW'(win_r) + LW'(1);

  // Only strictly higher priority pre-empts, and never beyond stack capacity.
  assign eligible = int_en & ready & (|pending_r) & (wlev > cur_level_r)
                  & (depth_r < DW'(DEPTH));

  // Set wins over clear: a fresh edge in the servicing cycle stays pending.
  assign clr_mask    = (state_r == S_ENTER) ? (NUM_IRQ'(1) << win_r) : '0;
  assign pending_nxt = (pending_r & ~clr_mask) | (irq_req & ~prev_r);

  assign depth_m1 = depth_r - DW'(1);
  assign push_idx = depth_r[AW-1:0];
  assign pop_idx  = depth_m1[AW-1:0];

  // Next-state logic. ERET beats a new entry; eret at depth 0 is dropped so
  // the EPC stack can never underflow.
  always_comb begin
    state_nxt = state_r;
    capture   = 1'b0;
    case (state_r)
      S_RUN: begin
        if (eret && (depth_r != '0)) begin
          state_nxt = S_RETURN;
        end else if (eligible) begin
          capture   = 1'b1;
          state_nxt = S_ENTER;
        end
      end
      S_ENTER:  state_nxt = S_RUN;
      S_RETURN: state_nxt = S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= S_RUN;
      prev_r      <= '0;
      pending_r   <= '0;
      cur_level_r <= '0;
      depth_r     <= '0;
      epc_data_r  <= '0;
      win_r       <= '0;
      for (int i = 0; i < DEPTH; i++) lvl_stack[i] <= '0;
    end else begin
      state_r   <= state_nxt;
      prev_r    <= irq_req;
      pending_r <= pending_nxt;
      if (capture) begin
        epc_data_r <= pc_cur;
        win_r      <= win;
      end
      case (state_r)
        S_ENTER: begin
          lvl_stack[push_idx] <= cur_level_r;
          cur_level_r         <= wlev_r;
          depth_r             <= depth_r + DW'(1);
        end
        S_RETURN: begin
          cur_level_r <= lvl_stack[pop_idx];
          depth_r     <= depth_m1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state, so they are glitch-free and all
  // drop to 0 the cycle after reset (an aborted ENTER/RETURN emits nothing).
  assign epc_en     = (state_r == S_ENTER) || (state_r == S_RETURN);
  assign epc_sel    = (state_r == S_RETURN);
  assign epc_data   = epc_data_r;
  assign int_take   = (state_r == S_ENTER);
  assign int_vector = (state_r == S_ENTER)
                    ? (VEC_BASE + (32'(win_r) << VEC_STRIDE_LOG2)) : 32'h0;
  assign eret_done  = (state_r == S_RETURN);
  assign cur_level  = cur_level_r;
  assign depth      = depth_r;
  assign pending    = pending_r;
  assign state_dbg  = state_r;

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Testbench for nested_int_ctrl, built with five sources so that nesting can
// reach the full depth of four. A queue-based reference model predicts every
// output cycle by cycle; directed steps cover the documented scenarios and a
// randomized phase follows.
module tb_nested_int_ctrl;

  localparam int N  = 5;
  localparam int D  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  irq_req;
  logic          int_en, ready, eret;
  logic [31:0]   pc_cur;
  logic          epc_en, epc_sel, int_take, eret_done;
  logic [31:0]   epc_data, int_vector;
  logic [2:0]    cur_level;
  logic [2:0]    depth;
  logic [N-1:0]  pending;
  logic [1:0]    state_dbg;

  nested_int_ctrl #(.NUM_IRQ(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .int_en(int_en), .ready(ready),
    .eret(eret), .pc_cur(pc_cur), .epc_en(epc_en), .epc_sel(epc_sel),
    .epc_data(epc_data), .int_take(int_take), .int_vector(int_vector),
    .eret_done(eret_done), .cur_level(cur_level), .depth(depth),
    .pending(pending), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // op: 0 = nothing, 1 = entry emitted this cycle, 2 = return emitted.
  int          m_level;
  int          m_stack[$];
  logic [N-1:0] m_pend, m_prev;
  int          m_op, m_win;
  logic [31:0] m_pc;
  logic [31:0] exp_q[$];   // expected pushed PCs, in order

  task automatic model_reset();
    m_level = 0; m_stack.delete(); m_pend = '0; m_prev = '0;
    m_op = 0; m_win = 0; m_pc = 32'h0; exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] edges;
    int hi, nxt;
    if (!rst) begin
      model_reset();
      return;
    end
    edges  = irq_req & ~m_prev;
    m_prev = irq_req;
    nxt    = 0;
    if (m_op == 1) begin
      m_stack.push_back(m_level);
      m_level = m_win + 1;
      m_pend[m_win] = 1'b0;
    end else if (m_op == 2) begin
      m_level = m_stack.pop_back();
    end else begin
      hi = -1;
      for (int i = 0; i < N; i++) if (m_pend[i]) hi = i;
      if (eret && m_stack.size() > 0) nxt = 2;
      else if (int_en && ready && hi >= 0 && hi + 1 > m_level && m_stack.size() < D) begin
        nxt = 1; m_win = hi; m_pc = pc_cur; exp_q.push_back(pc_cur);
      end
    end
    m_pend = m_pend | edges;
    m_op   = nxt;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    logic [31:0] e;
    @(negedge clk);
    chk("epc_en",     32'(epc_en),    32'(m_op != 0));
    chk("epc_sel",    32'(epc_sel),   32'(m_op == 2));
    chk("int_take",   32'(int_take),  32'(m_op == 1));
    chk("eret_done",  32'(eret_done), 32'(m_op == 2));
    chk("int_vector", int_vector, (m_op == 1) ? (32'h1000 + 32'(m_win) * 32'h100) : 32'h0);
    chk("epc_data",   epc_data, m_pc);
    chk("cur_level",  32'(cur_level), 32'(m_level));
    chk("depth",      32'(depth),     32'(m_stack.size()));
    chk("pending",    32'(pending),   32'(m_pend));
    if (epc_en === 1'b1 && epc_sel === 1'b0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("sb_push", epc_data, e);
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  // Edge on one line, then let it go through decision and entry.
  task automatic raise(input int idx, input logic [31:0] pc);
    pc_cur = pc;
    irq_req = '0; irq_req[idx] = 1'b1;
    tick();
    irq_req = '0;
    tick(); tick(); tick();
  endtask

  task automatic unwind();
    for (int k = 0; k < 8; k++) begin
      if (m_stack.size() > 0) begin
        eret = 1'b1; tick();
        eret = 1'b0; tick(); tick();
      end
    end
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; irq_req = '0; int_en = 1'b1; ready = 1'b1; eret = 1'b0;
    pc_cur = 32'h40;
    model_reset();
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    sample();
    chk("rst_epc_en", 32'(epc_en), 0);
    chk("rst_take", 32'(int_take), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_level", 32'(cur_level), 0);
    chk("rst_pending", 32'(pending), 0);
    advance();

    // Single entry on irq 0
    pc_cur = 32'h40; irq_req = 5'b00001; tick();
    irq_req = '0; tick();
    sample();
    chk("t1_take", 32'(int_take), 1);
    chk("t1_vec", int_vector, 32'h1000);
    chk("t1_push", 32'({epc_en, epc_sel}), 32'b10);
    chk("t1_data", epc_data, 32'h40);
    advance();
    sample();
    chk("t1_level", 32'(cur_level), 1);
    chk("t1_depth", 32'(depth), 1);
    chk("t1_pending", 32'(pending), 0);
    advance();

    // Nest irq 2, hold off irq 1, return, then irq 1 taken
    pc_cur = 32'h1010; irq_req = 5'b00100; tick();
    irq_req = '0; tick();
    sample();
    chk("t2_vec", int_vector, 32'h1200);
    chk("t2_data", epc_data, 32'h1010);
    advance();
    sample();
    chk("t2_level", 32'(cur_level), 3);
    chk("t2_depth", 32'(depth), 2);
    advance();
    irq_req = 5'b00010; tick();
    irq_req = '0; tick(); tick();
    sample();
    chk("t2_blocked_take", 32'(int_take), 0);
    chk("t2_blocked_pend", 32'(pending), 32'h2);
    advance();
    eret = 1'b1; tick();
    eret = 1'b0;
    sample();
    chk("t2_pop", 32'({epc_en, epc_sel, eret_done}), 32'b111);
    advance();
    sample();
    chk("t2_ret_level", 32'(cur_level), 1);
    advance();
    sample();
    chk("t2_irq1_vec", int_vector, 32'h1100);
    advance();
    sample();
    chk("t2_irq1_level", 32'(cur_level), 2);
    advance();

    // ERET and a higher-priority pending request in the same RUN cycle
    irq_req = 5'b01000; tick();
    irq_req = '0; eret = 1'b1; tick();
    eret = 1'b0;
    sample();
    chk("t3_ret_first", 32'(eret_done), 1);
    chk("t3_no_take", 32'(int_take), 0);
    advance();
    sample();
    chk("t3_depth", 32'(depth), 1);
    chk("t3_pend", 32'(pending), 32'h8);
    advance();
    sample();
    chk("t3_vec", int_vector, 32'h1300);
    advance();
    unwind();

    // Saturate at depth 4, then a higher edge must wait
    raise(0, 32'h100); raise(1, 32'h200); raise(2, 32'h300); raise(3, 32'h400);
    pc_cur = 32'h500; irq_req = 5'b10000; tick();
    irq_req = '0;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("t4_no_push", 32'(epc_en), 0);
      advance();
    end
    sample();
    chk("t4_depth", 32'(depth), 4);
    chk("t4_pend", 32'(pending), 32'h10);
    advance();
    eret = 1'b1; tick();
    eret = 1'b0; tick(); tick();
    sample();
    chk("t4_vec", int_vector, 32'h1400);
    advance();
    unwind();

    // eret at depth 0 is ignored
    eret = 1'b1; tick();
    eret = 1'b0;
    sample();
    chk("t5_eret_en", 32'(epc_en), 0);
    chk("t5_eret_done", 32'(eret_done), 0);
    advance();
    // Gated by int_en, then by ready
    int_en = 1'b0; pc_cur = 32'h77;
    irq_req = 5'b00100; tick();
    irq_req = '0; tick(); tick();
    int_en = 1'b1; ready = 1'b0; tick(); tick();
    sample();
    chk("t5_gated_take", 32'(int_take), 0);
    chk("t5_gated_pend", 32'(pending), 32'h4);
    advance();
    ready = 1'b1; tick();
    sample();
    chk("t5_take", 32'(int_take), 1);
    chk("t5_vec", int_vector, 32'h1200);
    advance();
    unwind();

    // Reset during the ENTER cycle
    pc_cur = 32'h99; irq_req = 5'b00010; tick();
    irq_req = '0; tick();
    rst = 1'b0;
    sample();
    chk("t6_in_enter", 32'(int_take), 1);
    advance();
    rst = 1'b1;
    sample();
    chk("t6_en", 32'(epc_en), 0);
    chk("t6_take", 32'(int_take), 0);
    chk("t6_depth", 32'(depth), 0);
    chk("t6_pend", 32'(pending), 0);
    advance();
    tick(); tick();

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 149) != 0);
      irq_req = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 31)) : '0;
      int_en  = ($urandom_range(0, 9) != 0);
      ready   = ($urandom_range(0, 7) != 0);
      eret    = ($urandom_range(0, 5) == 0);
      pc_cur  = $urandom;
      tick();
    end
    rst = 1'b1; irq_req = '0; eret = 1'b0; int_en = 1'b0;
    tick(); tick(); tick();
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
